// File: rtl/cordic_tanh_sched_if.sv
// Requester and result-consumer bus of the shared cordic_tanh scheduler.
// The scheduler uses the slave modport; the requesters and the consumer use master.
interface cordic_tanh_sched_if #(
    parameter int WI   = 8,
    parameter int WF   = 16,
    parameter int NREQ = 4,
    parameter int WR   = 2
);
    localparam int W = WI + WF;

    logic [NREQ-1:0]   iReq;
    logic [NREQ*W-1:0] iXArr;
    logic [NREQ*W-1:0] iYArr;
    logic [NREQ*W-1:0] iZArr;
    logic [NREQ-1:0]   oGnt;
    logic              oValid;
    logic              iReady;
    logic [WR-1:0]     oTag;
    logic [W-1:0]      oX;
    logic [W-1:0]      oY;
    logic [W-1:0]      oZ;
    logic              oErr;

    modport slave (
        input  iReq, iXArr, iYArr, iZArr, iReady,
        output oGnt, oValid, oTag, oX, oY, oZ, oErr
    );

    modport master (
        output iReq, iXArr, iYArr, iZArr, iReady,
        input  oGnt, oValid, oTag, oX, oY, oZ, oErr
    );
endinterface

// File: rtl/cordic_tanh_sched.sv
// Round-robin scheduler sharing one cordic_tanh core among NREQ requesters.
// Define CORDIC_SCHED_TIMEOUT_EN to build the RUN-state watchdog (oErr aborts).
module cordic_tanh_sched #(
    parameter int WI      = 8,
    parameter int WF      = 16,
    parameter int NREQ    = 4,
    parameter int WR      = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                iClk,
    input  logic                iRst,
    cordic_tanh_sched_if.slave  bus,
    output logic                oBusy,
    output logic                oCoreRst,
    output logic                oCoreStart,
    output logic [WI+WF-1:0]    oCoreX,
    output logic [WI+WF-1:0]    oCoreY,
    output logic [WI+WF-1:0]    oCoreZ,
    input  logic [WI+WF-1:0]    iCoreX,
    input  logic [WI+WF-1:0]    iCoreY,
    input  logic [WI+WF-1:0]    iCoreZ,
    input  logic                iCoreDone
);
    localparam int W = WI + WF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LAUNCH,
        S_RUN,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [WR-1:0]   ptr_q;
    logic [WR-1:0]   tag_q;
    logic [W-1:0]    arg_x_q, arg_y_q, arg_z_q;
    logic [W-1:0]    res_x_q, res_y_q, res_z_q;
    logic            valid_q;
    logic            core_rst_q;
    logic            start_q;

    logic [W-1:0]    lane_x [NREQ];
    logic [W-1:0]    lane_y [NREQ];
    logic [W-1:0]    lane_z [NREQ];
    logic [WR:0]     cand_sum [NREQ];
    logic [WR-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_req;
    logic [NREQ-1:0] gnt_vec;
    logic            pick_any;
    logic [WR-1:0]   pick_idx;
    logic [WR-1:0]   ptr_next;
    logic            grant_fire;
    logic            done_fire;
    logic            wd_expire;
    logic            xfer;

    // Candidate k is the requester k places after the pointer, wrapped modulo NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign lane_x[gi]   = bus.iXArr[gi*W +: W];
        assign lane_y[gi]   = bus.iYArr[gi*W +: W];
        assign lane_z[gi]   = bus.iZArr[gi*W +: W];
        assign cand_sum[gi] = {1'b0, ptr_q} + (WR+1)'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= (WR+1)'(NREQ))
                            ? WR'(cand_sum[gi] - (WR+1)'(NREQ))
                            : cand_sum[gi][WR-1:0];
        assign cand_req[gi] = bus.iReq[cand_idx[gi]];
        assign gnt_vec[gi]  = grant_fire && (pick_idx == WR'(gi));
    end

    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick_any = 1'b1;
                pick_idx = cand_idx[i];
            end
        end
    end

    assign ptr_next   = (pick_idx == WR'(NREQ - 1)) ? '0 : pick_idx + WR'(1);
    assign grant_fire = (state_q == S_IDLE) && pick_any;
    assign done_fire  = (state_q == S_RUN) && iCoreDone;
    assign xfer       = (state_q == S_OUT) && valid_q && bus.iReady;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q;
    logic           err_q;

    assign wd_expire = (state_q == S_RUN) && !iCoreDone && (wd_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_LAUNCH) begin
                wd_q <= '0;
            end else if (state_q == S_RUN) begin
                wd_q <= wd_q + WDW'(1);
            end
            if (done_fire) begin
                err_q <= 1'b0;
            end else if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.oErr = err_q;
`else
    // No watchdog hardware; RUN waits for the core indefinitely.
    if (TIMEOUT > 0) begin : g_no_watchdog
    end
    assign wd_expire = 1'b0;
    assign bus.oErr  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pick_any) state_d = S_CLR;
            S_CLR:    state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_RUN;
            S_RUN:    if (done_fire || wd_expire) state_d = S_OUT;
            S_OUT:    if (xfer) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Core reset and start are decoded from the next state so each is a clean flop output.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            tag_q      <= '0;
            arg_x_q    <= '0;
            arg_y_q    <= '0;
            arg_z_q    <= '0;
            res_x_q    <= '0;
            res_y_q    <= '0;
            res_z_q    <= '0;
            valid_q    <= 1'b0;
            core_rst_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= (state_d == S_CLR);
            start_q    <= (state_d == S_LAUNCH);
            if (grant_fire) begin
                arg_x_q <= lane_x[pick_idx];
                arg_y_q <= lane_y[pick_idx];
                arg_z_q <= lane_z[pick_idx];
                tag_q   <= pick_idx;
                ptr_q   <= ptr_next;
            end
            if (done_fire) begin
                res_x_q <= iCoreX;
                res_y_q <= iCoreY;
                res_z_q <= iCoreZ;
                valid_q <= 1'b1;
            end else if (wd_expire) begin
                res_x_q <= '0;
                res_y_q <= '0;
                res_z_q <= '0;
                valid_q <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.oGnt   = gnt_vec;
    assign bus.oValid = valid_q;
    assign bus.oTag   = tag_q;
    assign bus.oX     = res_x_q;
    assign bus.oY     = res_y_q;
    assign bus.oZ     = res_z_q;

    assign oBusy      = (state_q != S_IDLE);
    assign oCoreRst   = iRst | core_rst_q;
    assign oCoreStart = start_q;
    assign oCoreX     = arg_x_q;
    assign oCoreY     = arg_y_q;
    assign oCoreZ     = arg_z_q;
endmodule
